// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
// Defining MC_PERF_CNT_EN adds the cycle/instruction counter outputs.
interface mips_multicycle_ctrl_if #(
    parameter int ALUOP_W = 3
`ifdef MC_PERF_CNT_EN
    , parameter int PERF_W = 32
`endif
);
    logic [5:0]         opcode;
    logic [5:0]         func;
    logic               zero;
    logic               mem_ready;
    logic               pc_en;
    logic               iord;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               reg_dst;
    logic               jlselR;
    logic               jlselD;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               illegal;
`ifdef MC_PERF_CNT_EN
    logic [PERF_W-1:0]  cycle_cnt;
    logic [PERF_W-1:0]  instr_cnt;
`endif

    modport master (
        input  opcode, func, zero, mem_ready,
        output pc_en, iord, ir_write, mem_read, mem_write, reg_dst, jlselR, jlselD,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal
`ifdef MC_PERF_CNT_EN
        , output cycle_cnt, instr_cnt
`endif
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  pc_en, iord, ir_write, mem_read, mem_write, reg_dst, jlselR, jlselD,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal
`ifdef MC_PERF_CNT_EN
        , input cycle_cnt, instr_cnt
`endif
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the multi-cycle MIPS datapath; MC_PERF_CNT_EN adds cycle/instruction counters.
// Latency: beq/j/jal/jr 3, R-type/addi/slti/sw 4, lw 5 cycles with mem_ready high.
// Backpressure: FETCH, MEMRD and MEMWR hold their strobes until mem_ready; each wait adds a cycle.
module mips_multicycle_ctrl #(
    parameter int ALUOP_W = 3
`ifdef MC_PERF_CNT_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
        RWB, IMM_EXEC, IMM_WB, BRANCH, JUMP, JR, JAL
    } state_t;

    typedef struct packed {
        logic               pc_en;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               reg_dst;
        logic               jlselR;
        logic               jlselD;
        logic               mem_to_reg;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_src;
    } ctrl_t;

    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t n;
        n = FETCH;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: n = EXEC;
                    FN_JR:                                 n = JR;
                    default:                               n = FETCH;
                endcase
            end
            OP_LW, OP_SW:      n = MEMADR;
            OP_BEQ:            n = BRANCH;
            OP_ADDI, OP_SLTI:  n = IMM_EXEC;
            OP_J:              n = JUMP;
            OP_JAL:            n = JAL;
            default:           n = FETCH;
        endcase
        return n;
    endfunction

    function automatic logic [ALUOP_W-1:0] r_alu_op(input logic [5:0] fn);
        logic [ALUOP_W-1:0] a;
        case (fn)
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Moore outputs of the state being entered; registered alongside the state itself.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (s)
            FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:   c.alu_src_b = 2'b11;
            MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:    begin c.iord = 1'b1; c.mem_read = 1'b1; end
            MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            MEMWR:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
            EXEC:     begin c.alu_src_a = 1'b1; c.alu_op = r_alu_op(fn); end
            RWB:      begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            IMM_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            IMM_WB:   c.reg_write = 1'b1;
            BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'b01; end
            JUMP:     begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
            JR:       begin c.pc_src = 2'b11; c.pc_en = 1'b1; end
            JAL: begin
                c.pc_src    = 2'b10;
                c.pc_en     = 1'b1;
                c.reg_write = 1'b1;
                c.jlselR    = 1'b1;
                c.jlselD    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t state_q, state_d, dec_nxt;
    ctrl_t  ctrl_q;
    logic   is_sw_q;

    always_comb begin
        dec_nxt = decode_next(bus.opcode, bus.func);
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE:   state_d = dec_nxt;
            MEMADR:   state_d = is_sw_q ? MEMWR : MEMRD;
            MEMRD:    state_d = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:    state_d = bus.mem_ready ? FETCH : MEMWR;
            EXEC:     state_d = RWB;
            IMM_EXEC: state_d = IMM_WB;
            default:  state_d = FETCH;
        endcase
    end

    // lw/sw distinction is latched in DECODE so MEMADR never looks at the IR again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_of(FETCH, 6'd0, 6'd0);
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d, bus.opcode, bus.func);
            if (state_q == DECODE) begin
                is_sw_q <= (bus.opcode == OP_SW);
            end
        end
    end

    // Handshake-dependent terms and reset gating of every write strobe stay combinational.
    assign bus.pc_en      = ~rst & (ctrl_q.pc_en
                                    | ((state_q == FETCH)  & bus.mem_ready)
                                    | ((state_q == BRANCH) & bus.zero));
    assign bus.ir_write   = ~rst & (state_q == FETCH) & bus.mem_ready;
    assign bus.mem_read   = ~rst & ctrl_q.mem_read;
    assign bus.mem_write  = ~rst & ctrl_q.mem_write;
    assign bus.reg_write  = ~rst & ctrl_q.reg_write;
    assign bus.illegal    = ~rst & (state_q == DECODE) & (dec_nxt == FETCH);
    assign bus.iord       = ctrl_q.iord;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.jlselR     = ctrl_q.jlselR;
    assign bus.jlselD     = ctrl_q.jlselD;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.pc_src     = ctrl_q.pc_src;

`ifdef MC_PERF_CNT_EN
    logic [PERF_W-1:0] cycle_cnt_q;
    logic [PERF_W-1:0] instr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if ((state_d == FETCH) && (state_q != FETCH)) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected output streams built from instruction classes.
module tb_mips_multicycle_ctrl;
    logic clk;
    logic rst;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       jlselR;
        logic       jlselD;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctl_t;

    localparam int C_R = 0, C_JR = 1, C_LW = 2, C_SW = 3, C_BEQ = 4,
                   C_ADDI = 5, C_SLTI = 6, C_J = 7, C_JAL = 8, C_ILL = 9;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    ctl_t       exq [$];
    logic       mrq [$];
    logic       zq  [$];
    bit         fq  [$];
    logic [5:0] cur_op;
    logic [5:0] cur_fn;
    logic [5:0] rfn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    function automatic ctl_t observe();
        ctl_t o;
        o.pc_en      = bus.pc_en;
        o.iord       = bus.iord;
        o.ir_write   = bus.ir_write;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.reg_dst    = bus.reg_dst;
        o.jlselR     = bus.jlselR;
        o.jlselD     = bus.jlselD;
        o.mem_to_reg = bus.mem_to_reg;
        o.reg_write  = bus.reg_write;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_op     = bus.alu_op;
        o.pc_src     = bus.pc_src;
        o.illegal    = bus.illegal;
        return o;
    endfunction

    function automatic ctl_t idle();
        ctl_t c;
        c        = '0;
        c.alu_op = 3'b010;
        return c;
    endfunction

    function automatic logic [2:0] r_op(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0)
            return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
        return op inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001010, 6'b000010, 6'b000011};
    endfunction

    task automatic push(input ctl_t c, input logic mr, input logic z, input bit f);
        exq.push_back(c);
        mrq.push_back(mr);
        zq.push_back(z);
        fq.push_back(f);
    endtask

    // Expected cycle-by-cycle outputs of one instruction: fw fetch waits, mw data-memory waits.
    task automatic build(input int cls, input logic [5:0] op, input logic [5:0] fn,
                         input int fw, input int mw, input logic bz);
        ctl_t c;
        cur_op = op;
        cur_fn = fn;
        for (int i = 0; i <= fw; i++) begin
            c = idle();
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            c.ir_write  = (i == fw);
            c.pc_en     = (i == fw);
            push(c, (i == fw), 1'($urandom), 1'b1);
        end
        c = idle();
        c.alu_src_b = 2'b11;
        c.illegal   = (cls == C_ILL);
        push(c, 1'($urandom), 1'($urandom), 1'b0);
        if (cls == C_LW || cls == C_SW) begin
            c = idle();
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            push(c, 1'($urandom), 1'($urandom), 1'b0);
            for (int i = 0; i <= mw; i++) begin
                c = idle();
                c.iord      = 1'b1;
                c.mem_read  = (cls == C_LW);
                c.mem_write = (cls == C_SW);
                push(c, (i == mw), 1'($urandom), 1'b0);
            end
        end
        case (cls)
            C_R: begin
                c = idle(); c.alu_src_a = 1'b1; c.alu_op = r_op(fn);
                push(c, 1'($urandom), 1'($urandom), 1'b0);
                c = idle(); c.reg_dst = 1'b1; c.reg_write = 1'b1;
                push(c, 1'($urandom), 1'($urandom), 1'b0);
            end
            C_LW: begin
                c = idle(); c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                push(c, 1'($urandom), 1'($urandom), 1'b0);
            end
            C_ADDI, C_SLTI: begin
                c = idle(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                c.alu_op = (cls == C_SLTI) ? 3'b111 : 3'b010;
                push(c, 1'($urandom), 1'($urandom), 1'b0);
                c = idle(); c.reg_write = 1'b1;
                push(c, 1'($urandom), 1'($urandom), 1'b0);
            end
            C_BEQ: begin
                c = idle(); c.alu_src_a = 1'b1; c.alu_op = 3'b110; c.pc_src = 2'b01; c.pc_en = bz;
                push(c, 1'($urandom), bz, 1'b0);
            end
            C_J, C_JR, C_JAL: begin
                c = idle(); c.pc_en = 1'b1;
                c.pc_src = (cls == C_JR) ? 2'b11 : 2'b10;
                if (cls == C_JAL) begin
                    c.reg_write = 1'b1; c.jlselR = 1'b1; c.jlselD = 1'b1;
                end
                push(c, 1'($urandom), 1'($urandom), 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic pick(input int cls, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (cls)
            C_R:     begin op = 6'b000000; fn = rfn[$urandom_range(0, 4)]; end
            C_JR:    begin op = 6'b000000; fn = 6'b001000; end
            C_LW:    op = 6'b100011;
            C_SW:    op = 6'b101011;
            C_BEQ:   op = 6'b000100;
            C_ADDI:  op = 6'b001000;
            C_SLTI:  op = 6'b001010;
            C_J:     op = 6'b000010;
            C_JAL:   op = 6'b000011;
            default: begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                    if ($urandom_range(0, 1) == 0) op = 6'd0;
                end while (is_legal(op, fn));
            end
        endcase
    endtask

    task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_strobes(input string tag);
        logic [5:0] obs;
        obs = {bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.illegal};
        checks++;
        assert (obs === 6'b000000)
        else begin
            errors++;
            $error("FAIL %s: strobes observed=%b expected=000000", tag, obs);
        end
    endtask

    // Drives up to n queued cycles starting just after a falling edge; IR is garbage during FETCH.
    task automatic run_n(input int n);
        ctl_t e;
        bit   f;
        for (int k = 0; k < n && exq.size() > 0; k++) begin
            e = exq.pop_front();
            bus.mem_ready = mrq.pop_front();
            bus.zero      = zq.pop_front();
            f             = fq.pop_front();
            bus.opcode    = f ? 6'($urandom) : cur_op;
            bus.func      = f ? 6'($urandom) : cur_fn;
            #1;
            check($sformatf("cyc%0d op=%b fn=%b", cyc, cur_op, cur_fn), observe(), e);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_instr(input int cls, input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input logic bz);
        build(cls, op, fn, fw, mw, bz);
        run_n(1000);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        rst           = 1'b1;
        bus.opcode    = 6'd0;
        bus.func      = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_strobes("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        do_instr(C_R,   6'b000000, 6'b100000, 0, 0, 1'b0);
        do_instr(C_LW,  6'b100011, 6'b010101, 1, 2, 1'b0);
        do_instr(C_BEQ, 6'b000100, 6'b000000, 0, 0, 1'b1);
        do_instr(C_BEQ, 6'b000100, 6'b000000, 0, 0, 1'b0);
        do_instr(C_JAL, 6'b000011, 6'b110011, 0, 0, 1'b0);
        do_instr(C_JR,  6'b000000, 6'b001000, 0, 0, 1'b0);
        do_instr(C_ILL, 6'b111111, 6'b000000, 0, 0, 1'b0);
        do_instr(C_SW,  6'b101011, 6'b000000, 0, 1, 1'b0);

        for (int n = 0; n < 80; n++) begin
            cls = $urandom_range(0, 9);
            pick(cls, op, fn);
            do_instr(cls, op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        // Reset raised while a store is stalled in MEMWR must kill mem_write at once.
        build(C_SW, 6'b101011, 6'b000000, 0, 3, 1'b0);
        run_n(4);
        exq.delete(); mrq.delete(); zq.delete(); fq.delete();
        bus.mem_ready = 1'b0;
        rst           = 1'b1;
        #1;
        check_strobes("rst_in_memwr");
        @(negedge clk);
        #1;
        check_strobes("rst_in_memwr_hold");
        @(negedge clk);
        rst = 1'b0;
        do_instr(C_ADDI, 6'b001000, 6'b000000, 0, 0, 1'b0);
        do_instr(C_SLTI, 6'b001010, 6'b000000, 1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
